// File: rtl/maindec_issue_if.sv
// Decode/issue bundle between IF/ID and ID/EX: instruction handshake in,
// registered control bundle plus FPU interlock status out.
interface maindec_issue_if;
  logic       in_valid, in_ready;
  logic [5:0] op, funct;
  logic       flush;
  logic       out_valid, out_ready;
  logic       regwrite, regdst, alusrc, branch, ne, memwrite, memtoreg, jump, jr, link;
  logic [1:0] ls_ctrl, aluop;
  logic [2:0] fpu_control;
  logic       fp_regwrite, fpu_mem_write, mem_to_fp, illegal;
  logic       fpu_busy;

  modport master (
    output in_valid, op, funct, flush, out_ready,
    input  in_ready, out_valid, regwrite, regdst, alusrc, branch, ne, memwrite,
           memtoreg, jump, jr, link, ls_ctrl, aluop, fpu_control, fp_regwrite,
           fpu_mem_write, mem_to_fp, illegal, fpu_busy
  );

  modport slave (
    input  in_valid, op, funct, flush, out_ready,
    output in_ready, out_valid, regwrite, regdst, alusrc, branch, ne, memwrite,
           memtoreg, jump, jr, link, ls_ctrl, aluop, fpu_control, fp_regwrite,
           fpu_mem_write, mem_to_fp, illegal, fpu_busy
  );
endinterface

// File: rtl/maindec_issue.sv
// Registered MIPS main decoder with valid/ready handshake and an FP interlock
// that holds FP instructions while a multi-cycle FPU mul/div is in flight.
module maindec_issue #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input logic           clk_i,
  input logic           reset_n_i,
  maindec_issue_if.slave bus
);
  localparam int CW = $clog2(DIV_LAT) + 1;

  localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011, OP_LH   = 6'b100001,
                         OP_LB   = 6'b100000, OP_LBU  = 6'b100100, OP_SW   = 6'b101011,
                         OP_SH   = 6'b101001, OP_SB   = 6'b101000, OP_BEQ  = 6'b000100,
                         OP_BNE  = 6'b000101, OP_ADDI = 6'b001000, OP_ORI  = 6'b001101,
                         OP_J    = 6'b000010, OP_JAL  = 6'b000011, OP_LWC1 = 6'b110001,
                         OP_SWC1 = 6'b111001, OP_COP1 = 6'b010001;

  typedef struct packed {
    logic       regwrite, regdst, alusrc, branch, ne, memwrite, memtoreg, jump, jr, link;
    logic [1:0] ls_ctrl;
    logic [1:0] aluop;
    logic [2:0] fpu_control;
    logic       fp_regwrite, fpu_mem_write, mem_to_fp, illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  fp;
    logic  mul;
    logic  div;
  } entry_t;

  entry_t        ent_d, ent_q;
  logic          valid_d, valid_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          fpu_busy, out_valid, issue, in_ready, accept;
  logic [1:0]    ls_w;

  // Width code falls out of op[2:0]: x11 word, x01 half, x00 byte, 100 byte-unsigned.
  assign ls_w = bus.op[2] ? 2'b11 : bus.op[1] ? 2'b00 : bus.op[0] ? 2'b01 : 2'b10;

  always_comb begin
    ent_d = '0;
    unique case (bus.op)
      OP_R: begin
        ent_d.ctrl.regwrite = 1'b1;
        ent_d.ctrl.regdst   = 1'b1;
        ent_d.ctrl.aluop    = 2'b10;
        if (bus.funct == 6'b001000) begin
          ent_d.ctrl.jr       = 1'b1;
          ent_d.ctrl.regwrite = 1'b0;
        end
        if (bus.funct == 6'b001001) begin
          ent_d.ctrl.jr   = 1'b1;
          ent_d.ctrl.link = 1'b1;
        end
      end
      OP_LW, OP_LH, OP_LB, OP_LBU: begin
        ent_d.ctrl.regwrite = 1'b1;
        ent_d.ctrl.alusrc   = 1'b1;
        ent_d.ctrl.memtoreg = 1'b1;
        ent_d.ctrl.ls_ctrl  = ls_w;
      end
      OP_SW, OP_SH, OP_SB: begin
        ent_d.ctrl.alusrc   = 1'b1;
        ent_d.ctrl.memwrite = 1'b1;
        ent_d.ctrl.ls_ctrl  = ls_w;
      end
      OP_BEQ, OP_BNE: begin
        ent_d.ctrl.branch = 1'b1;
        ent_d.ctrl.ne     = bus.op[0];
        ent_d.ctrl.aluop  = 2'b01;
      end
      OP_ADDI: begin
        ent_d.ctrl.regwrite = 1'b1;
        ent_d.ctrl.alusrc   = 1'b1;
      end
      OP_ORI: begin
        ent_d.ctrl.regwrite = 1'b1;
        ent_d.ctrl.alusrc   = 1'b1;
        ent_d.ctrl.aluop    = 2'b11;
      end
      OP_J: ent_d.ctrl.jump = 1'b1;
      OP_JAL: begin
        ent_d.ctrl.jump     = 1'b1;
        ent_d.ctrl.link     = 1'b1;
        ent_d.ctrl.regwrite = 1'b1;
      end
      OP_LWC1: begin
        ent_d.ctrl.alusrc      = 1'b1;
        ent_d.ctrl.mem_to_fp   = 1'b1;
        ent_d.ctrl.fp_regwrite = 1'b1;
        ent_d.fp               = 1'b1;
      end
      OP_SWC1: begin
        ent_d.ctrl.alusrc        = 1'b1;
        ent_d.ctrl.fpu_mem_write = 1'b1;
        ent_d.fp                 = 1'b1;
      end
      OP_COP1: begin
        if (bus.funct inside {6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000101, 6'b000111}) begin
          ent_d.ctrl.fp_regwrite = 1'b1;
          ent_d.ctrl.fpu_control = bus.funct[2:0];
          ent_d.fp               = 1'b1;
          ent_d.mul              = (bus.funct == 6'b000010);
          ent_d.div              = (bus.funct == 6'b000011);
        end else begin
          ent_d.ctrl.illegal = 1'b1;
        end
      end
      default: ent_d.ctrl.illegal = 1'b1;
    endcase
  end

  assign fpu_busy  = (cnt_q != '0);
  assign out_valid = valid_q & ~(ent_q.fp & fpu_busy);
  assign issue     = out_valid & bus.out_ready;
  assign in_ready  = ~valid_q | issue;
  assign accept    = bus.in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    if (issue)    valid_d = 1'b0;
    if (accept)   valid_d = 1'b1;
    if (bus.flush) valid_d = 1'b0;

    // Flush never touches the counter: an issued long op is already in EX.
    cnt_d = cnt_q;
    if (issue && ent_q.mul)      cnt_d = CW'(MUL_LAT - 1);
    else if (issue && ent_q.div) cnt_d = CW'(DIV_LAT - 1);
    else if (fpu_busy)           cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) ent_q <= ent_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.fpu_busy  = fpu_busy;
  assign {bus.regwrite, bus.regdst, bus.alusrc, bus.branch, bus.ne, bus.memwrite,
          bus.memtoreg, bus.jump, bus.jr, bus.link, bus.ls_ctrl, bus.aluop,
          bus.fpu_control, bus.fp_regwrite, bus.fpu_mem_write, bus.mem_to_fp,
          bus.illegal} = ent_q.ctrl;
endmodule

// File: tb/tb_maindec_issue.sv
// Directed bench for maindec_issue: cycle-level reference of the held entry and
// FPU busy window, plus hand-computed literal expectations per scenario.
module tb_maindec_issue;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011, OP_LH   = 6'b100001,
                         OP_LB   = 6'b100000, OP_LBU  = 6'b100100, OP_SW   = 6'b101011,
                         OP_SH   = 6'b101001, OP_SB   = 6'b101000, OP_BEQ  = 6'b000100,
                         OP_BNE  = 6'b000101, OP_ADDI = 6'b001000, OP_ORI  = 6'b001101,
                         OP_J    = 6'b000010, OP_JAL  = 6'b000011, OP_LWC1 = 6'b110001,
                         OP_SWC1 = 6'b111001, OP_COP1 = 6'b010001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  maindec_issue_if bus();

  maindec_issue #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [20:0] dut_b;
  assign dut_b = {bus.regwrite, bus.regdst, bus.alusrc, bus.branch, bus.ne, bus.memwrite,
                  bus.memtoreg, bus.jump, bus.jr, bus.link, bus.ls_ctrl, bus.aluop,
                  bus.fpu_control, bus.fp_regwrite, bus.fpu_mem_write, bus.mem_to_fp,
                  bus.illegal};

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic cop1_legal(input logic [5:0] fn);
    return (fn == 6'd0) || (fn == 6'd1) || (fn == 6'd2) || (fn == 6'd3) || (fn == 6'd5) || (fn == 6'd7);
  endfunction

  function automatic logic is_fp(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_LWC1) || (op == OP_SWC1) || (op == OP_COP1 && cop1_legal(fn));
  endfunction

  function automatic int long_lat(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_COP1 && fn == 6'd2) return MUL_LAT;
    if (op == OP_COP1 && fn == 6'd3) return DIV_LAT;
    return 0;
  endfunction

  function automatic logic [20:0] ref_bundle(input logic [5:0] op, input logic [5:0] fn);
    logic rw, rd, as, br, ne, mw, mr, j, jr, lk, fw, fmw, mfp, ill;
    logic [1:0] ls, alu;
    logic [2:0] fc;
    rw = 0; rd = 0; as = 0; br = 0; ne = 0; mw = 0; mr = 0; j = 0; jr = 0; lk = 0;
    fw = 0; fmw = 0; mfp = 0; ill = 0; ls = 2'b00; alu = 2'b00; fc = 3'b000;
    case (op)
      OP_R: begin
        rw = 1; rd = 1; alu = 2'b10;
        if (fn == 6'b001000) begin jr = 1; rw = 0; end
        if (fn == 6'b001001) begin jr = 1; lk = 1; end
      end
      OP_LW:   begin rw = 1; as = 1; mr = 1; ls = 2'b00; end
      OP_LH:   begin rw = 1; as = 1; mr = 1; ls = 2'b01; end
      OP_LB:   begin rw = 1; as = 1; mr = 1; ls = 2'b10; end
      OP_LBU:  begin rw = 1; as = 1; mr = 1; ls = 2'b11; end
      OP_SW:   begin as = 1; mw = 1; ls = 2'b00; end
      OP_SH:   begin as = 1; mw = 1; ls = 2'b01; end
      OP_SB:   begin as = 1; mw = 1; ls = 2'b10; end
      OP_BEQ:  begin br = 1; alu = 2'b01; end
      OP_BNE:  begin br = 1; ne = 1; alu = 2'b01; end
      OP_ADDI: begin rw = 1; as = 1; end
      OP_ORI:  begin rw = 1; as = 1; alu = 2'b11; end
      OP_J:    j = 1;
      OP_JAL:  begin j = 1; lk = 1; rw = 1; end
      OP_LWC1: begin as = 1; mfp = 1; fw = 1; end
      OP_SWC1: begin as = 1; fmw = 1; end
      OP_COP1: if (cop1_legal(fn)) begin fw = 1; fc = fn[2:0]; end else ill = 1;
      default: ill = 1;
    endcase
    return {rw, rd, as, br, ne, mw, mr, j, jr, lk, ls, alu, fc, fw, fmw, mfp, ill};
  endfunction

  // Model: one held slot, and the cycle index from which FP entries may issue.
  bit         m_vld = 1'b0;
  logic [5:0] m_op = '0, m_fn = '0;
  int         m_free = 0;
  int         cyc = 0;

  logic exp_busy, exp_ov, exp_is, exp_ir;
  assign exp_busy = (cyc < m_free);
  assign exp_ov   = m_vld && !(is_fp(m_op, m_fn) && exp_busy);
  assign exp_is   = exp_ov && bus.out_ready;
  assign exp_ir   = !m_vld || exp_is;

  initial forever begin : model
    bit acc, iss;
    @(posedge clk);
    acc = bus.in_valid && exp_ir;
    iss = exp_is;
    if (!reset_n) begin
      m_vld  = 1'b0;
      m_free = 0;
    end else begin
      if (iss && long_lat(m_op, m_fn) > 0) m_free = cyc + long_lat(m_op, m_fn);
      if (bus.flush)  m_vld = 1'b0;
      else if (acc)   m_vld = 1'b1;
      else if (iss)   m_vld = 1'b0;
      if (acc) begin
        m_op = bus.op;
        m_fn = bus.funct;
      end
    end
    cyc++;
  end

  initial forever begin : compare
    @(negedge clk);
    check("out_valid", bus.out_valid, exp_ov);
    check("in_ready", bus.in_ready, exp_ir);
    check("fpu_busy", bus.fpu_busy, exp_busy);
    if (m_vld) check("bundle", dut_b, ref_bundle(m_op, m_fn));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  localparam logic [20:0] L_LW   = 21'b1_0_1_0_0_0_1_0_0_0_00_00_000_0000;
  localparam logic [20:0] L_SW   = 21'b0_0_1_0_0_1_0_0_0_0_00_00_000_0000;
  localparam logic [20:0] L_LH   = 21'b1_0_1_0_0_0_1_0_0_0_01_00_000_0000;
  localparam logic [20:0] L_ADDI = 21'b1_0_1_0_0_0_0_0_0_0_00_00_000_0000;
  localparam logic [20:0] L_FADD = 21'b0_0_0_0_0_0_0_0_0_0_00_00_000_1000;
  localparam logic [20:0] L_ILL  = 21'b0_0_0_0_0_0_0_0_0_0_00_00_000_0001;

  logic [5:0]  sops [5];
  logic [20:0] slit [5];
  logic [5:0]  wop  [14];
  logic [5:0]  wfn  [14];
  int stall;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sops = '{OP_LB, OP_SH, OP_BNE, OP_JAL, OP_ORI};
    slit = '{21'b1_0_1_0_0_0_1_0_0_0_10_00_000_0000,
             21'b0_0_1_0_0_1_0_0_0_0_01_00_000_0000,
             21'b0_0_0_1_1_0_0_0_0_0_00_01_000_0000,
             21'b1_0_0_0_0_0_0_1_0_1_00_00_000_0000,
             21'b1_0_1_0_0_0_0_0_0_0_00_11_000_0000};
    wop = '{OP_R, OP_R, OP_R, OP_LBU, OP_SB, OP_J, OP_LWC1, OP_SWC1, OP_BEQ,
            OP_COP1, OP_COP1, OP_COP1, OP_COP1, OP_LW};
    wfn = '{6'b100000, 6'b001000, 6'b001001, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
            6'd2, 6'd7, 6'd5, 6'd1, 6'd0};

    bus.in_valid = 1'b1; bus.op = OP_LW; bus.funct = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    mid();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_fpu_busy", bus.fpu_busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_bundle", dut_b, 0);

    // first post-reset LW
    reset_n = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    mid();
    check("lw_valid", bus.out_valid, 1);
    check("lw_bundle", dut_b, L_LW);
    tick();

    // back-to-back stream
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.op = sops[i]; bus.funct = '0;
      tick();
      mid();
      check($sformatf("stream%0d_valid", i), bus.out_valid, 1);
      check($sformatf("stream%0d_bundle", i), dut_b, slit[i]);
    end
    bus.in_valid = 1'b0;
    tick();

    // div then add: add held DIV_LAT-1 cycles
    bus.in_valid = 1'b1; bus.op = OP_COP1; bus.funct = 6'd3;
    tick();
    bus.funct = 6'd0;
    tick();
    bus.in_valid = 1'b0;
    stall = 0;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (bus.out_valid) break;
      stall++;
      tick();
    end
    check("div_stall_cycles", stall, 11);
    check("fadd_fpu_control", bus.fpu_control, 0);
    check("fadd_bundle", dut_b, L_FADD);
    tick();

    // div, ADDI, add: ADDI issues under busy
    bus.in_valid = 1'b1; bus.op = OP_COP1; bus.funct = 6'd3;
    tick();
    bus.op = OP_ADDI; bus.funct = 6'd0;
    tick();
    bus.op = OP_COP1; bus.funct = 6'd0;
    mid();
    check("addi_valid", bus.out_valid, 1);
    check("addi_busy", bus.fpu_busy, 1);
    check("addi_bundle", dut_b, L_ADDI);
    tick();
    bus.in_valid = 1'b0;
    stall = 0;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (bus.out_valid) break;
      stall++;
      tick();
    end
    check("div_addi_stall_cycles", stall, 10);
    tick();

    // mul then add
    bus.in_valid = 1'b1; bus.op = OP_COP1; bus.funct = 6'd2;
    tick();
    bus.funct = 6'd0;
    tick();
    bus.in_valid = 1'b0;
    stall = 0;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (bus.out_valid) break;
      stall++;
      tick();
    end
    check("mul_stall_cycles", stall, 3);
    tick();

    // SW held by out_ready=0 for 5 cycles, then LH follows with no bubble
    bus.in_valid = 1'b1; bus.op = OP_SW; bus.funct = '0;
    tick();
    bus.op = OP_LH; bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mid();
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_bundle", dut_b, L_SW);
      tick();
    end
    bus.out_ready = 1'b1;
    mid();
    check("release_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    mid();
    check("lh_valid", bus.out_valid, 1);
    check("lh_bundle", dut_b, L_LH);
    tick();

    // flush same cycle as BEQ accept, mul issuing at that edge
    bus.in_valid = 1'b1; bus.op = OP_COP1; bus.funct = 6'd2;
    tick();
    bus.op = OP_BEQ; bus.funct = '0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    mid();
    check("flush_valid", bus.out_valid, 0);
    check("flush_busy", bus.fpu_busy, 1);
    repeat (4) tick();

    // illegal encodings
    bus.in_valid = 1'b1; bus.op = 6'b111111; bus.funct = '0;
    tick();
    bus.in_valid = 1'b0;
    mid();
    check("ill_op_valid", bus.out_valid, 1);
    check("ill_op_bundle", dut_b, L_ILL);
    tick();
    bus.in_valid = 1'b1; bus.op = OP_COP1; bus.funct = 6'b000100;
    tick();
    bus.in_valid = 1'b0;
    mid();
    check("ill_cop1_bundle", dut_b, L_ILL);
    tick();

    // illegal COP1 is not FP-class: not held behind a div
    bus.in_valid = 1'b1; bus.op = OP_COP1; bus.funct = 6'd3;
    tick();
    bus.funct = 6'b000100;
    tick();
    bus.in_valid = 1'b0;
    mid();
    check("ill_busy_valid", bus.out_valid, 1);
    check("ill_busy_busy", bus.fpu_busy, 1);
    tick();

    // reset while an FP entry is stalled
    bus.in_valid = 1'b1; bus.op = OP_COP1; bus.funct = 6'd0;
    tick();
    bus.in_valid = 1'b0;
    mid();
    check("prerst_stalled", bus.out_valid, 0);
    reset_n = 1'b0;
    tick();
    mid();
    check("rst2_valid", bus.out_valid, 0);
    check("rst2_busy", bus.fpu_busy, 0);
    check("rst2_in_ready", bus.in_ready, 1);
    reset_n = 1'b1;
    tick();

    // mixed sweep with intermittent back-pressure
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = 1'b1; bus.op = wop[i]; bus.funct = wfn[i];
      bus.out_ready = (i % 3 != 2);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
